// File: rtl/glitch_pkg.sv
// Shared glitch rig definitions: measurement FSM state encoding,
// generator state encoding and the default measurement timeout.
package glitch_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    WIDTH    = 3'd2,
    REPORT   = 3'd3,
    WAIT_REL = 3'd4
  } meas_state_t;

  typedef enum logic [1:0] {
    READY = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2,
    DONE  = 2'd3
  } gen_state_t;

  localparam logic [31:0] DEF_TIMEOUT_COUNT = 32'd600000;

endpackage

// File: rtl/glitch_meas_sync2.sv
// Two-flop synchronizer for a single asynchronous line.
// Ports: clk, rst (async, active high), d (async in), q (synchronized out).
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/glitch_meas.sv
// Glitch measurement: counts trigger-rise to glitch-rise delay and glitch
// high time in clk cycles and reports them over a valid/ready handshake.
// Ports: clk, rst (async, active high), trigger, glitch_in,
//   meas_valid/meas_ready handshake, delay_count, width_count, timeout, busy.
// Build option: GLITCH_MEAS_SYNC_EN adds 2-flop synchronizers on both inputs.
import glitch_pkg::*;

module glitch_meas #(
  parameter int          CNT_WIDTH     = 32,
  parameter logic [31:0] TIMEOUT_COUNT = DEF_TIMEOUT_COUNT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger,
  input  logic                 glitch_in,
  output logic                 meas_valid,
  input  logic                 meas_ready,
  output logic [CNT_WIDTH-1:0] delay_count,
  output logic [CNT_WIDTH-1:0] width_count,
  output logic                 timeout,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] TO  = CNT_WIDTH'(TIMEOUT_COUNT);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic trig_s;
  logic glitch_s;
  logic trig_d;

`ifdef GLITCH_MEAS_SYNC_EN
  // Equal latency on both lines keeps the measured intervals unchanged.
  sync2 u_sync_trig (
    .clk (clk),
    .rst (rst),
    .d   (trigger),
    .q   (trig_s)
  );

  sync2 u_sync_glitch (
    .clk (clk),
    .rst (rst),
    .d   (glitch_in),
    .q   (glitch_s)
  );
`else
  assign trig_s   = trigger;
  assign glitch_s = glitch_in;
`endif

  meas_state_t          state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [CNT_WIDTH-1:0] wcnt, wcnt_n;
  logic [CNT_WIDTH-1:0] delay_n, width_n;
  logic                 valid_n, tmo_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wcnt        <= '0;
      trig_d      <= 1'b0;
      delay_count <= '0;
      width_count <= '0;
      meas_valid  <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      wcnt        <= wcnt_n;
      trig_d      <= trig_s;
      delay_count <= delay_n;
      width_count <= width_n;
      meas_valid  <= valid_n;
      timeout     <= tmo_n;
      busy        <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wcnt_n  = wcnt;
    delay_n = delay_count;
    width_n = width_count;
    valid_n = meas_valid;
    tmo_n   = timeout;
    unique case (state)
      IDLE: begin
        if (trig_s && !trig_d) begin
          tmo_n = 1'b0;
          if (glitch_s) begin
            // Glitch coincident with the trigger edge: zero delay.
            delay_n = '0;
            wcnt_n  = ONE;
            state_n = WIDTH;
          end else begin
            cnt_n   = ONE;
            state_n = ARMED;
          end
        end
      end
      ARMED: begin
        if (glitch_s) begin
          delay_n = cnt;
          wcnt_n  = ONE;
          state_n = WIDTH;
        end else if (cnt == TO) begin
          delay_n = cnt;
          width_n = '0;
          tmo_n   = 1'b1;
          valid_n = 1'b1;
          state_n = REPORT;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      WIDTH: begin
        if (!glitch_s) begin
          width_n = wcnt;
          valid_n = 1'b1;
          state_n = REPORT;
        end else if (wcnt == TO) begin
          width_n = wcnt;
          tmo_n   = 1'b1;
          valid_n = 1'b1;
          state_n = REPORT;
        end else begin
          wcnt_n = wcnt + ONE;
        end
      end
      REPORT: begin
        if (meas_valid && meas_ready) begin
          valid_n = 1'b0;
          // A still-high trigger must fall before it can re-arm.
          state_n = trig_s ? WAIT_REL : IDLE;
        end
      end
      WAIT_REL: begin
        if (!trig_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_glitch_meas.sv
// Self-checking bench for glitch_meas: table of nominal measurements plus
// hand-written timeout, backpressure, reset and ignored-activity sequences.
module tb_glitch_meas;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic        glitch_in;
  logic        meas_valid;
  logic        meas_ready;
  logic [31:0] delay_count;
  logic [31:0] width_count;
  logic        timeout;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] w;
    logic        t;
  } res_t;

  typedef struct {
    int unsigned dly;
    int unsigned wid;
    logic [31:0] exp_d;
    logic [31:0] exp_w;
  } vec_t;

  res_t sb[$];
  vec_t vecs[6];

  glitch_meas #(
    .CNT_WIDTH     (32),
    .TIMEOUT_COUNT (32'd1000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trigger     (trigger),
    .glitch_in   (glitch_in),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .delay_count (delay_count),
    .width_count (width_count),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int maxc, input string tag);
    bit   seen;
    res_t e;
    seen = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (meas_valid) begin
        seen = 1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_valid actual=0 required=1 (no result)", tag);
    end else if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s_extra actual=valid required=no result", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_delay"}, delay_count, e.d);
      chk({tag, "_width"}, width_count, e.w);
      chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, e.t});
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic count_valids(input int n, input string tag);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (meas_valid) c++;
    end
    chk(tag, c, 0);
  endtask

  // Trigger rises, glitch rises dly cycles later for wid cycles, and the
  // trigger is released with the glitch fall.
  task automatic run(input int unsigned dly, input int unsigned wid,
                     input logic [31:0] ed, input logic [31:0] ew,
                     input string tag);
    @(posedge clk) #1;
    sb.push_back('{d: ed, w: ew, t: 1'b0});
    trigger = 1'b1;
    repeat (dly) @(posedge clk) #1;
    glitch_in = 1'b1;
    repeat (wid) @(posedge clk) #1;
    glitch_in = 1'b0;
    trigger   = 1'b0;
    wait_valid(dly + wid + 20, tag);
    @(negedge clk);
    chk({tag, "_valid_1cyc"}, {31'd0, meas_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] hd, hw;

    vecs[0] = '{100, 50, 32'd100, 32'd50};
    vecs[1] = '{0,   1,  32'd0,   32'd1};
    vecs[2] = '{1,   1,  32'd1,   32'd1};
    vecs[3] = '{5,   3,  32'd5,   32'd3};
    vecs[4] = '{2,   10, 32'd2,   32'd10};
    vecs[5] = '{37,  1,  32'd37,  32'd1};

    rst        = 1'b1;
    trigger    = 1'b0;
    glitch_in  = 1'b0;
    meas_ready = 1'b1;
    #1;
    chk("rst_valid", {31'd0, meas_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_delay", delay_count, 32'd0);
    chk("rst_width", width_count, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run(vecs[i].dly, vecs[i].wid, vecs[i].exp_d, vecs[i].exp_w,
          $sformatf("vec%0d", i));
      repeat (2) @(posedge clk);
    end

    // Delay timeout: glitch never rises.
    @(posedge clk) #1;
    sb.push_back('{d: 32'd1000, w: 32'd0, t: 1'b1});
    trigger = 1'b1;
    wait_valid(1100, "dly_to");
    @(negedge clk);
    chk("dly_to_waitrel_busy", {31'd0, busy}, 32'd1);
    trigger = 1'b0;
    repeat (2) @(negedge clk);
    chk("dly_to_idle_busy", {31'd0, busy}, 32'd0);
    chk("dly_to_hold_timeout", {31'd0, timeout}, 32'd1);

    // Width timeout: glitch stays high too long.
    @(posedge clk) #1;
    sb.push_back('{d: 32'd3, w: 32'd1000, t: 1'b1});
    trigger = 1'b1;
    repeat (3) @(posedge clk) #1;
    glitch_in = 1'b1;
    chk("wid_to_timeout_cleared", {31'd0, timeout}, 32'd0);
    wait_valid(1100, "wid_to");
    trigger   = 1'b0;
    glitch_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("wid_to_idle_busy", {31'd0, busy}, 32'd0);

    // Backpressure: ready low for 20 cycles of valid.
    meas_ready = 1'b0;
    @(posedge clk) #1;
    sb.push_back('{d: 32'd10, w: 32'd4, t: 1'b0});
    trigger = 1'b1;
    repeat (10) @(posedge clk) #1;
    glitch_in = 1'b1;
    repeat (4) @(posedge clk) #1;
    glitch_in = 1'b0;
    wait_valid(40, "bp");
    hd = delay_count;
    hw = width_count;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", i), {31'd0, meas_valid}, 32'd1);
      chk($sformatf("bp_hold_delay%0d", i), delay_count, 32'd10);
      chk($sformatf("bp_hold_width%0d", i), width_count, 32'd4);
    end
    meas_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_clear", {31'd0, meas_valid}, 32'd0);
    chk("bp_waitrel_busy", {31'd0, busy}, 32'd1);
    chk("bp_retain_delay", delay_count, hd);
    chk("bp_retain_width", width_count, hw);
    count_valids(5, "bp_no_second");
    trigger = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp_idle_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a width count.
    @(posedge clk) #1;
    trigger = 1'b1;
    repeat (5) @(posedge clk) #1;
    glitch_in = 1'b1;
    repeat (4) @(posedge clk) #1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, meas_valid}, 32'd0);
    chk("mid_rst_delay", delay_count, 32'd0);
    chk("mid_rst_width", width_count, 32'd0);
    trigger   = 1'b0;
    glitch_in = 1'b0;
    @(posedge clk) #1 rst = 1'b0;
    count_valids(3, "mid_rst_no_result");
    run(7, 2, 32'd7, 32'd2, "post_rst");

    // Glitch with no trigger edge is ignored.
    @(posedge clk) #1;
    glitch_in = 1'b1;
    repeat (3) @(posedge clk) #1;
    glitch_in = 1'b0;
    count_valids(10, "lone_glitch");
    chk("lone_glitch_busy", {31'd0, busy}, 32'd0);

    // Trigger held across a second glitch after the report.
    @(posedge clk) #1;
    sb.push_back('{d: 32'd4, w: 32'd2, t: 1'b0});
    trigger = 1'b1;
    repeat (4) @(posedge clk) #1;
    glitch_in = 1'b1;
    repeat (2) @(posedge clk) #1;
    glitch_in = 1'b0;
    wait_valid(20, "held");
    @(negedge clk);
    chk("held_waitrel_busy", {31'd0, busy}, 32'd1);
    glitch_in = 1'b1;
    repeat (3) @(negedge clk);
    glitch_in = 1'b0;
    count_valids(10, "held_second_glitch");
    chk("held_still_busy", {31'd0, busy}, 32'd1);
    trigger = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_idle_busy", {31'd0, busy}, 32'd0);
    run(6, 3, 32'd6, 32'd3, "rearm");

    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/glitch_meas.md
# glitch_meas

Measurement-side counterpart to the glitch generator. It watches a trigger and a glitch line and counts two intervals in `clk` cycles: trigger rising edge to glitch rising edge, and glitch high time. It reports both to a host over a valid/ready handshake. It is used on the bench to characterise generator delay and pulse-width settings, and as a closed-loop check in the glitch rig.

## Interface
- `CNT_WIDTH`, 32, width of the delay and width counters and result ports.
- `TIMEOUT_COUNT`, 32'd600000, maximum cycles spent waiting for the glitch, or counting its width, before the measurement is aborted with `timeout`.
- `clk` in 1: measurement clock (PLL output in the system).
- `rst` in 1: asynchronous, active-high reset.
- `trigger` in 1: trigger line, the same signal that drives the generator.
- `glitch_in` in 1: glitch line under test.
- `meas_valid` out 1: result available.
- `meas_ready` in 1: host accepts the result.
- `delay_count` out CNT_WIDTH: cycles from trigger rise to glitch rise.
- `width_count` out CNT_WIDTH: cycles glitch was high.
- `timeout` out 1: result is aborted, and the counts hold partial values.
- `busy` out 1: high in every state other than IDLE.

## Operation
- `trig_s` and `glitch_s` are the conditioned inputs (see Configuration). `trig_d` is `trig_s` registered once and is used for rising-edge detection.
- **Reset:** state=IDLE; `meas_valid`, `delay_count`, `width_count`, `timeout` and `busy` = 0. `trig_d` = 0.
- **State IDLE:**
  - On `trig_s && !trig_d` with `glitch_s`=0: go to ARMED with delay counter = 1.
  - On the same edge with `glitch_s`=1: go to WIDTH with delay = 0 and width counter = 1.
- **State ARMED:**
  - `glitch_s`=1: capture `delay_count` = counter, set width counter = 1, go to WIDTH.
  - Otherwise: if counter == TIMEOUT_COUNT, capture counter, `timeout`=1, width = 0, go to REPORT. Else increment the counter.
- **State WIDTH:**
  - `glitch_s`=0: capture `width_count` = width counter, go to REPORT.
  - Else if width counter == TIMEOUT_COUNT: capture it, `timeout`=1, go to REPORT.
  - Else increment the width counter.
- **State REPORT:**
  - `meas_valid`=1 and the results are stable.
  - On `meas_valid && meas_ready`: clear `meas_valid`. Go to WAIT_REL if `trig_s`=1, else IDLE.
- **State WAIT_REL:** `trig_s`=0 → IDLE.
- **Result retention:** results hold their last value after the handshake. `timeout` clears on the next IDLE→ARMED/WIDTH transition.
- **Trigger behaviour:**
  - A trigger fall during ARMED or WIDTH is ignored; measurement continues.
  - A trigger re-rise during REPORT or WAIT_REL is ignored.
- **Glitch behaviour:** glitch activity in IDLE without a trigger edge is ignored.
- **Arithmetic:** counters are unsigned CNT_WIDTH. The TIMEOUT_COUNT comparison guarantees no wrap, provided TIMEOUT_COUNT < 2^CNT_WIDTH.

## Timing
- The delay value N means `glitch_s` first went high N cycles after the first cycle `trig_s` was high. The width value W equals the number of consecutive cycles `glitch_s` was high.
- `meas_valid` rises on the cycle after the first `glitch_s`=0 sample in WIDTH.
- On a timeout, `meas_valid` rises on the cycle after the counter equals TIMEOUT_COUNT.
- `meas_ready` may be held high in advance. The handshake completes on the first cycle `meas_valid` is high, so the minimum REPORT dwell is 1 cycle.
- `busy` is registered and matches state≠IDLE.
- An asynchronous `rst` mid-measurement returns everything to its reset values immediately. No result is emitted.

## Configuration
- `GLITCH_MEAS_SYNC_EN` defined:
  - `trigger` and `glitch_in` each pass through a 2-flop synchronizer before use.
  - This adds 2 cycles of input latency, identical on both lines, so measured values are unchanged.
  - Synchronizer flops reset to 0.
- Undefined: `trig_s`=`trigger` and `glitch_s`=`glitch_in` directly. Both inputs must then be synchronous to `clk`.

## Structure
- The shared package `glitch_pkg` holds:
  - the state encoding (IDLE, ARMED, WIDTH, REPORT, WAIT_REL; 3 bits);
  - the default TIMEOUT_COUNT constant;
  - the READY/DELAY/PULSE/DONE encoding, shared with the generator.
- Sub-module `sync2`: a 2-flop synchronizer with async active-high reset. It is instantiated twice, only under `GLITCH_MEAS_SYNC_EN`.

## Test plan
- **Nominal measurement:** trigger rises at cycle 0, glitch high cycles 100–149, ready=1 → delay_count=100, width_count=50, timeout=0, valid for 1 cycle.
- **Coincident edges:** trigger and glitch rise the same cycle, glitch high for 1 cycle → delay_count=0, width_count=1.
- **Delay timeout:** TIMEOUT_COUNT=1000, glitch never rises → valid with timeout=1, delay_count=1000, width_count=0.
- **Backpressure:** ready=0 for 20 cycles after valid, then 1 → outputs stable all 20 cycles. One handshake, then WAIT_REL until trigger falls.
- **Reset mid-measurement:** rst asserted in WIDTH → busy=0, valid=0 and counts=0 immediately. The next trigger measures cleanly.
- **Ignored activity:** a glitch pulse with no trigger edge, then trigger held high across a second glitch after the report → no extra valid until trigger falls and rises again.
